// File: rtl/packet_switch_stream_dbg_cntr_if.sv
// AVMM CSR bus plus monitored AXI-Stream tap signals for the stream debug counter bank.
// The master drives CSR requests and stream taps; the slave returns read data.
interface packet_switch_stream_dbg_cntr_if #(
   parameter int NUM_CHNL   = 8,
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 32
);
   logic [ADDR_WIDTH-1:0]   avmm_address;
   logic                    avmm_write;
   logic [DATA_WIDTH-1:0]   avmm_writedata;
   logic [DATA_WIDTH/8-1:0] avmm_byteenable;
   logic                    avmm_read;
   logic [DATA_WIDTH-1:0]   avmm_readdata;
   logic                    avmm_readdatavalid;
   logic [NUM_CHNL-1:0]     mon_tvalid;
   logic [NUM_CHNL-1:0]     mon_tready;
   logic [NUM_CHNL-1:0]     mon_tlast;

   modport master (
      output avmm_address, avmm_write, avmm_writedata, avmm_byteenable, avmm_read,
             mon_tvalid, mon_tready, mon_tlast,
      input  avmm_readdata, avmm_readdatavalid
   );

   modport slave (
      input  avmm_address, avmm_write, avmm_writedata, avmm_byteenable, avmm_read,
             mon_tvalid, mon_tready, mon_tlast,
      output avmm_readdata, avmm_readdatavalid
   );
endinterface

// File: rtl/packet_switch_stream_dbg_cntr.sv
// Per-channel AXI-Stream packet/stall counter bank with an AVMM CSR slave.
// Counter k = 2*channel + {0: packets, 1: stalls}; CSR word 0x10 + 2k is its LO, 0x11 + 2k its HI.
module packet_switch_stream_dbg_cntr #(
   parameter int NUM_CHNL   = 8,
   parameter int CNTR_WIDTH = 32,
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 32,
   parameter int SATURATE   = 0
) (
   input logic clk,
   input logic rst_n,
   packet_switch_stream_dbg_cntr_if.slave bus
);

   localparam int NUM_CNTR = 2 * NUM_CHNL;
   localparam logic [CNTR_WIDTH-1:0] CNT_MAX = '1;
   localparam logic [31:0] ID_WORD = {8'(NUM_CHNL), 8'(CNTR_WIDTH), 16'h5D01};

   logic [31:0]                           addr_w;
   logic                                  wr_ctrl, clear_all, wr_status;
   logic [NUM_CNTR-1:0]                   ev_in, ev_q;
   logic [NUM_CNTR-1:0]                   lo_sel, hi_sel, ovf;
   logic [NUM_CNTR-1:0][CNTR_WIDTH-1:0]   cnt_q, cnt_d;
   logic [NUM_CNTR-1:0][31:0]             snap_q, snap_d;
   logic [NUM_CHNL-1:0]                   status_q, status_d;
   logic                                  freeze_q, clr_on_rd_q;
   logic [DATA_WIDTH-1:0]                 rd_data, readdata_q;
   logic                                  readdatavalid_q;
   logic                                  unused_bus;

   assign addr_w    = 32'(bus.avmm_address);
   assign wr_ctrl   = bus.avmm_write && (addr_w == 32'd0) && bus.avmm_byteenable[0];
   assign clear_all = wr_ctrl && bus.avmm_writedata[0];
   assign wr_status = bus.avmm_write && (addr_w == 32'd1);
   assign unused_bus = &{1'b0, bus.avmm_writedata, bus.avmm_byteenable};

   always_comb begin : event_decode
      ev_in = '0;
      for (int c = 0; c < NUM_CHNL; c++) begin
         ev_in[2*c]   = bus.mon_tvalid[c] & bus.mon_tready[c] & bus.mon_tlast[c];
         ev_in[2*c+1] = bus.mon_tvalid[c] & ~bus.mon_tready[c];
      end
   end

   always_comb begin : addr_decode
      lo_sel = '0;
      hi_sel = '0;
      for (int k = 0; k < NUM_CNTR; k++) begin
         if (addr_w == 32'(16 + 2*k)) lo_sel[k] = 1'b1;
         if (addr_w == 32'(17 + 2*k)) hi_sel[k] = 1'b1;
      end
   end

   // Read mux always sees pre-update state, so clear-on-read returns the pre-clear value.
   always_comb begin : read_mux
      logic [63:0] cnt64;
      rd_data = '0;
      cnt64   = '0;
      case (addr_w)
         32'd0:   rd_data = DATA_WIDTH'({clr_on_rd_q, freeze_q, 1'b0});
         32'd1:   rd_data = DATA_WIDTH'(status_q);
         32'd2:   rd_data = DATA_WIDTH'(ID_WORD);
         default: begin
            for (int k = 0; k < NUM_CNTR; k++) begin
               cnt64 = 64'(cnt_q[k]);
               if (lo_sel[k]) rd_data = rd_data | DATA_WIDTH'(cnt64[31:0]);
               if (hi_sel[k]) rd_data = rd_data | DATA_WIDTH'(snap_q[k]);
            end
         end
      endcase
   end

   // NOTE: every variable this block writes gets a default first, so no latch is inferred.
   always_comb begin : cntr_next
      logic [63:0] cnt64;
      logic        lo_rd;
      cnt_d  = cnt_q;
      snap_d = snap_q;
      ovf    = '0;
      cnt64  = '0;
      lo_rd  = 1'b0;
      for (int k = 0; k < NUM_CNTR; k++) begin
         cnt64 = 64'(cnt_q[k]);
         lo_rd = bus.avmm_read && lo_sel[k];
         if (lo_rd) snap_d[k] = cnt64[63:32];
         if (clear_all) begin
            cnt_d[k] = '0;
         end else if (clr_on_rd_q && lo_rd) begin
            cnt_d[k] = CNTR_WIDTH'(ev_q[k] && !freeze_q);
         end else if (!freeze_q && ev_q[k]) begin
            if (cnt_q[k] == CNT_MAX) begin
               ovf[k]   = 1'b1;
               cnt_d[k] = (SATURATE != 0) ? CNT_MAX : '0;
            end else begin
               cnt_d[k] = cnt_q[k] + CNTR_WIDTH'(1);
            end
         end
      end
   end

   // A W1C on a bit that overflows in the same cycle leaves that bit set.
   always_comb begin : status_next
      status_d = status_q;
      for (int c = 0; c < NUM_CHNL; c++) begin
         if (wr_status && bus.avmm_writedata[c] && bus.avmm_byteenable[c/8])
            status_d[c] = 1'b0;
         if (ovf[2*c] || ovf[2*c+1])
            status_d[c] = 1'b1;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ev_q            <= '0;
         cnt_q           <= '0;
         snap_q          <= '0;
         status_q        <= '0;
         freeze_q        <= 1'b0;
         clr_on_rd_q     <= 1'b0;
         readdata_q      <= '0;
         readdatavalid_q <= 1'b0;
      end else begin
         ev_q            <= ev_in;
         cnt_q           <= cnt_d;
         snap_q          <= snap_d;
         status_q        <= status_d;
         readdatavalid_q <= bus.avmm_read;
         readdata_q      <= bus.avmm_read ? rd_data : '0;
         if (wr_ctrl) begin
            freeze_q    <= bus.avmm_writedata[1];
            clr_on_rd_q <= bus.avmm_writedata[2];
         end
      end
   end

   assign bus.avmm_readdata      = readdata_q;
   assign bus.avmm_readdatavalid = readdatavalid_q;

endmodule

// File: tb/tb_packet_switch_stream_dbg_cntr.sv
// Drives four counter-bank configurations (32-bit, 64-bit, 4-bit wrap, 4-bit saturate) with
// identical stimulus and compares every read response against a cycle-level reference model.
module tb_packet_switch_stream_dbg_cntr;

   localparam int NM = 4;
   localparam int NC = 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [7:0]  a_addr = '0;
   logic        a_write = 1'b0, a_read = 1'b0;
   logic [31:0] a_wdata = '0;
   logic [3:0]  a_be = '0;
   logic [7:0]  tv = '0, tr = '0, tl = '0;

   logic [31:0] rdata [NM];
   logic        rdv   [NM];

   packet_switch_stream_dbg_cntr_if #(.NUM_CHNL(NC), .ADDR_WIDTH(8), .DATA_WIDTH(32)) bus [NM] ();

   for (genvar g = 0; g < NM; g++) begin : g_conn
      assign bus[g].avmm_address    = a_addr;
      assign bus[g].avmm_write      = a_write;
      assign bus[g].avmm_writedata  = a_wdata;
      assign bus[g].avmm_byteenable = a_be;
      assign bus[g].avmm_read       = a_read;
      assign bus[g].mon_tvalid      = tv;
      assign bus[g].mon_tready      = tr;
      assign bus[g].mon_tlast       = tl;
      assign rdata[g]               = bus[g].avmm_readdata;
      assign rdv[g]                 = bus[g].avmm_readdatavalid;
   end

   packet_switch_stream_dbg_cntr #(.NUM_CHNL(NC), .CNTR_WIDTH(32), .ADDR_WIDTH(8), .DATA_WIDTH(32), .SATURATE(0))
      u_dut32 (.clk(clk), .rst_n(rst_n), .bus(bus[0]));
   packet_switch_stream_dbg_cntr #(.NUM_CHNL(NC), .CNTR_WIDTH(64), .ADDR_WIDTH(8), .DATA_WIDTH(32), .SATURATE(0))
      u_dut64 (.clk(clk), .rst_n(rst_n), .bus(bus[1]));
   packet_switch_stream_dbg_cntr #(.NUM_CHNL(NC), .CNTR_WIDTH(4), .ADDR_WIDTH(8), .DATA_WIDTH(32), .SATURATE(0))
      u_dut4w (.clk(clk), .rst_n(rst_n), .bus(bus[2]));
   packet_switch_stream_dbg_cntr #(.NUM_CHNL(NC), .CNTR_WIDTH(4), .ADDR_WIDTH(8), .DATA_WIDTH(32), .SATURATE(1))
      u_dut4s (.clk(clk), .rst_n(rst_n), .bus(bus[3]));

   // Reference model state: counter values as plain integers, per configuration.
   int          cw  [NM] = '{32, 64, 4, 4};
   bit          sat [NM] = '{0, 0, 0, 1};
   logic [63:0] m_cnt  [NM][2*NC];
   logic [63:0] m_snap [NM][2*NC];
   logic [7:0]  m_status [NM];
   logic        m_freeze, m_clr;
   logic [15:0] m_ev;

   int total = 0;
   int bad   = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int m = 0; m < NM; m++) begin
         for (int k = 0; k < 2*NC; k++) begin
            m_cnt[m][k]  = '0;
            m_snap[m][k] = '0;
         end
         m_status[m] = '0;
      end
      m_freeze = 1'b0;
      m_clr    = 1'b0;
      m_ev     = '0;
   endtask

   // One clock: apply the rules to the model with the inputs present at the edge, then check outputs.
   task automatic tick();
      logic [31:0] rexp [NM];
      logic [63:0] mx;
      logic [7:0]  ovf;
      logic [15:0] ev_now;
      bit          clr_all, lo, rd_now;
      int          k;
      @(posedge clk);
      rd_now  = a_read;
      clr_all = a_write && a_addr == 8'd0 && a_be[0] && a_wdata[0];
      for (int c = 0; c < NC; c++) begin
         ev_now[2*c]   = tv[c] & tr[c] & tl[c];
         ev_now[2*c+1] = tv[c] & ~tr[c];
      end
      for (int m = 0; m < NM; m++) begin
         mx = (cw[m] == 64) ? '1 : (64'd1 << cw[m]) - 64'd1;
         rexp[m] = '0;
         ovf = '0;
         if (rd_now) begin
            if (a_addr == 8'd0)      rexp[m] = {29'd0, m_clr, m_freeze, 1'b0};
            else if (a_addr == 8'd1) rexp[m] = {24'd0, m_status[m]};
            else if (a_addr == 8'd2) rexp[m] = {8'd8, 8'(cw[m]), 16'h5D01};
            else if (a_addr >= 8'd16 && a_addr < 8'd48) begin
               k = (int'(a_addr) - 16) / 2;
               if (a_addr[0] == 1'b0) begin
                  rexp[m] = m_cnt[m][k][31:0];
                  m_snap[m][k] = m_cnt[m][k] >> 32;
               end else begin
                  rexp[m] = m_snap[m][k][31:0];
               end
            end
         end
         for (int j = 0; j < 2*NC; j++) begin
            lo = rd_now && int'(a_addr) == 16 + 2*j;
            if (clr_all) m_cnt[m][j] = '0;
            else if (m_clr && lo) m_cnt[m][j] = (m_ev[j] && !m_freeze) ? 64'd1 : 64'd0;
            else if (!m_freeze && m_ev[j]) begin
               if (m_cnt[m][j] == mx) begin
                  ovf[j/2] = 1'b1;
                  if (!sat[m]) m_cnt[m][j] = '0;
               end else begin
                  m_cnt[m][j] = m_cnt[m][j] + 64'd1;
               end
            end
         end
         if (a_write && a_addr == 8'd1 && a_be[0]) m_status[m] = m_status[m] & ~a_wdata[7:0];
         m_status[m] = m_status[m] | ovf;
      end
      if (a_write && a_addr == 8'd0 && a_be[0]) begin
         m_freeze = a_wdata[1];
         m_clr    = a_wdata[2];
      end
      m_ev = ev_now;
      #1;
      for (int m = 0; m < NM; m++) begin
         check($sformatf("rdv dut%0d", m), 64'(rdv[m]), 64'(rd_now));
         if (rd_now) check($sformatf("rd dut%0d @%0h", m, a_addr), 64'(rdata[m]), 64'(rexp[m]));
      end
   endtask

   task automatic idle(input int n);
      repeat (n) tick();
   endtask

   task automatic bus_read(input logic [7:0] addr);
      a_addr = addr;
      a_read = 1'b1;
      tick();
      a_read = 1'b0;
   endtask

   task automatic bus_write(input logic [7:0] addr, input logic [31:0] d);
      a_addr  = addr;
      a_wdata = d;
      a_be    = 4'hF;
      a_write = 1'b1;
      tick();
      a_write = 1'b0;
   endtask

   task automatic pkt_cycle(input int ch);
      tv = '0; tr = '0; tl = '0;
      tv[ch] = 1'b1; tr[ch] = 1'b1; tl[ch] = 1'b1;
      tick();
      tv = '0; tr = '0; tl = '0;
   endtask

   // One packet of 'beats' beats with exactly 'stalls' backpressure cycles at random positions.
   task automatic send_pkt(input int ch, input int beats, input int stalls);
      int left, ns;
      left = stalls;
      for (int b = 0; b < beats; b++) begin
         ns = (b == beats - 1) ? left : int'($urandom_range(left, 0));
         repeat (ns) begin
            tv[ch] = 1'b1; tr[ch] = 1'b0; tl[ch] = (b == beats - 1);
            tick();
         end
         left -= ns;
         tv[ch] = 1'b1; tr[ch] = 1'b1; tl[ch] = (b == beats - 1);
         tick();
      end
      tv = '0; tr = '0; tl = '0;
      idle(int'($urandom_range(2, 0)));
   endtask

   task automatic read_all_counters();
      for (int a = 16; a < 48; a++) bus_read(8'(a));
   endtask

   initial begin : stimulus
      logic [15:0][63:0] preload;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      for (int m = 0; m < NM; m++) begin
         check($sformatf("reset rdv dut%0d", m), 64'(rdv[m]), 64'd0);
         check($sformatf("reset rdata dut%0d", m), 64'(rdata[m]), 64'd0);
      end
      @(negedge clk);
      rst_n = 1'b1;

      // ID and zeroed registers after reset
      bus_read(8'h02);
      check("id default", 64'(rdata[0]), 64'h0820_5D01);
      bus_read(8'h00);
      bus_read(8'h01);
      bus_read(8'h10);

      // Channel 3: 5 packets of 4 beats, 2 stalls each
      for (int p = 0; p < 5; p++) send_pkt(3, 4, 2);
      idle(2);
      bus_read(8'h1C);
      check("ch3 pkt", 64'(rdata[0]), 64'd5);
      bus_read(8'h1E);
      check("ch3 stall", 64'(rdata[0]), 64'd10);
      read_all_counters();

      // Random traffic on every channel with interleaved random reads
      for (int i = 0; i < 150; i++) begin
         tv = 8'($urandom); tr = 8'($urandom); tl = 8'($urandom);
         a_read = ($urandom_range(3, 0) == 0);
         a_addr = 8'($urandom_range(47, 0));
         tick();
      end
      a_read = 1'b0;
      tv = '0; tr = '0; tl = '0;
      idle(2);
      read_all_counters();
      bus_read(8'h01);

      // 64-bit coherency: preload ch0 PKT of the 64-bit instance above 2^32
      bus_write(8'h00, 32'h1);
      bus_write(8'h01, 32'hFF);
      preload = '0;
      preload[0] = 64'h1_0000_0003;
      force u_dut64.cnt_q = preload;
      #1;
      release u_dut64.cnt_q;
      m_cnt[1][0] = 64'h1_0000_0003;
      bus_read(8'h10);
      check("w64 lo first", 64'(rdata[1]), 64'd3);
      for (int i = 0; i < 10; i++) pkt_cycle(0);
      idle(2);
      bus_read(8'h11);
      check("w64 hi snapshot", 64'(rdata[1]), 64'd1);
      bus_read(8'h10);
      check("w64 lo second", 64'(rdata[1]), 64'd13);
      bus_read(8'h11);

      // 4-bit wrap vs saturate, sticky overflow and same-cycle W1C
      bus_write(8'h00, 32'h1);
      bus_write(8'h01, 32'hFF);
      for (int i = 0; i < 17; i++) pkt_cycle(0);
      idle(2);
      bus_read(8'h10);
      check("w4 wrap pkt", 64'(rdata[2]), 64'd1);
      check("w4 sat pkt", 64'(rdata[3]), 64'd15);
      bus_read(8'h01);
      check("w4 wrap status", 64'(rdata[2]), 64'h1);
      check("w4 sat status", 64'(rdata[3]), 64'h1);
      bus_write(8'h01, 32'h1);
      bus_read(8'h01);
      check("w4 status w1c", 64'(rdata[2]), 64'h0);
      for (int i = 0; i < 14; i++) pkt_cycle(0);
      idle(2);
      pkt_cycle(0);
      bus_write(8'h01, 32'h1);
      bus_read(8'h01);
      check("w4 w1c vs ovf wrap", 64'(rdata[2]), 64'h1);
      check("w4 w1c vs ovf sat", 64'(rdata[3]), 64'h1);

      // Clear-on-read with an event landing in the read cycle
      bus_write(8'h00, 32'h1);
      bus_write(8'h00, 32'h4);
      for (int i = 0; i < 7; i++) pkt_cycle(1);
      idle(2);
      pkt_cycle(1);
      bus_read(8'h14);
      check("cor first", 64'(rdata[0]), 64'd7);
      idle(2);
      bus_read(8'h14);
      check("cor second", 64'(rdata[0]), 64'd1);

      // Freeze holds counters while traffic continues
      bus_write(8'h00, 32'h0);
      for (int i = 0; i < 3; i++) pkt_cycle(1);
      idle(2);
      bus_write(8'h00, 32'h2);
      for (int i = 0; i < 4; i++) pkt_cycle(1);
      idle(2);
      bus_read(8'h14);
      check("freeze hold", 64'(rdata[0]), 64'd3);
      bus_read(8'h00);
      bus_write(8'h00, 32'h0);

      // CLEAR_ALL drops an event landing in the same cycle
      pkt_cycle(2);
      pkt_cycle(2);
      idle(2);
      pkt_cycle(2);
      bus_write(8'h00, 32'h1);
      idle(2);
      bus_read(8'h18);
      check("clear vs event", 64'(rdata[0]), 64'd0);

      // Reset asserted while a read is pending
      bus_write(8'h00, 32'h6);
      a_addr = 8'h02;
      a_read = 1'b1;
      #2;
      rst_n = 1'b0;
      model_reset();
      @(posedge clk);
      #1;
      for (int m = 0; m < NM; m++) check($sformatf("rst mid-read rdv dut%0d", m), 64'(rdv[m]), 64'd0);
      @(negedge clk);
      rst_n  = 1'b1;
      a_read = 1'b0;
      idle(3);
      bus_read(8'h00);
      bus_read(8'h10);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
